// File: rtl/bcd_ctrl_pkg.sv
// Shared types and constants for the BCD stopwatch controller and its digit cells.
package bcd_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } sw_state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd_digit.sv
// Single BCD digit register: clears on clr, advances 0..9 on inc, flags the 9 state.
import bcd_ctrl_pkg::*;

module bcd_digit (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    output bcd_digit_t value,
    output logic       at_max
);

    bcd_digit_t value_q;
    bcd_digit_t value_d;

    always_comb begin
        value_d = value_q;
        if (clr) begin
            value_d = '0;
        end else if (inc) begin
            value_d = (value_q == BCD_MAX) ? 4'd0 : value_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value  = value_q;
    assign at_max = (value_q == BCD_MAX);

endmodule

// File: rtl/bcd_stopwatch_ctrl.sv
// Run/pause/clear stopwatch: prescaled tick drives a cascade of BCD digits.
// Optional lap snapshot display is built when LAP_STOPWATCH_EN is defined.
import bcd_ctrl_pkg::*;

module bcd_stopwatch_ctrl #(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  stop_i,
    input  logic                  clear_i,
`ifdef LAP_STOPWATCH_EN
    input  logic                  lap_i,
`endif
    output logic [4*DIGITS-1:0]   count_o,
    output logic                  running_o,
    output logic                  wrap_o
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    sw_state_t       state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic            wrap_q;
    logic            tick;
    logic [DIGITS:0] carry;
    logic [DIGITS-1:0] at_max;
    logic [4*DIGITS-1:0] live;

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        tick    = 1'b0;
        case (state_q)
            IDLE: begin
                presc_d = '0;
                if (!clear_i && start_i) state_d = RUN;
            end
            RUN: begin
                if (clear_i) begin
                    state_d = IDLE;
                    presc_d = '0;
                end else if (stop_i) begin
                    // Pausing suppresses the tick but keeps the phase, so a
                    // prescaler already at its last value waits there.
                    state_d = PAUSE;
                    if (presc_q != PRESC_LAST) presc_d = presc_q + 1'b1;
                end else begin
                    tick    = (presc_q == PRESC_LAST);
                    presc_d = tick ? '0 : presc_q + 1'b1;
                end
            end
            PAUSE: begin
                if (clear_i) begin
                    state_d = IDLE;
                    presc_d = '0;
                end else if (start_i && !stop_i) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
                presc_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            presc_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            wrap_q  <= carry[DIGITS];
        end
    end

    // Single-edge carry: digit k increments when the tick is present and every lower digit is 9.
    assign carry[0] = tick;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit_t dval;
        bcd_digit u_digit (
            .clk    (clk),
            .rst    (rst),
            .clr    (clear_i),
            .inc    (carry[g]),
            .value  (dval),
            .at_max (at_max[g])
        );
        assign live[4*g +: 4] = dval;
        assign carry[g+1]     = carry[g] & at_max[g];
    end

`ifdef LAP_STOPWATCH_EN
    logic                lap_prev_q;
    logic                lap_mode_q;
    logic [4*DIGITS-1:0] snap_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lap_prev_q <= 1'b0;
            lap_mode_q <= 1'b0;
            snap_q     <= '0;
        end else begin
            lap_prev_q <= lap_i;
            if (clear_i) begin
                lap_mode_q <= 1'b0;
                snap_q     <= '0;
            end else if (lap_i && !lap_prev_q) begin
                lap_mode_q <= !lap_mode_q;
                if (!lap_mode_q) snap_q <= live;
            end
        end
    end

    assign count_o = lap_mode_q ? snap_q : live;
`else
    assign count_o = live;
`endif

    assign running_o = (state_q == RUN);
    assign wrap_o    = wrap_q;

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Directed bench for bcd_stopwatch_ctrl with DIGITS=2, TICK_DIV=4 (lap checks under LAP_STOPWATCH_EN).
module tb_bcd_stopwatch_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_i, stop_i, clear_i;
    logic       lap_i;
    logic [7:0] count_o;
    logic       running_o, wrap_o;

    int n_tests = 0;
    int n_fail  = 0;

    bcd_stopwatch_ctrl #(.DIGITS(2), .TICK_DIV(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start_i),
        .stop_i    (stop_i),
        .clear_i   (clear_i),
`ifdef LAP_STOPWATCH_EN
        .lap_i     (lap_i),
`endif
        .count_o   (count_o),
        .running_o (running_o),
        .wrap_o    (wrap_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       st;
        logic       sp;
        logic       cl;
        logic [7:0] cnt;
        logic       run;
        logic       wr;
    } vec_t;

    vec_t tbl[18];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic s, input logic p, input logic c);
        start_i = s;
        stop_i  = p;
        clear_i = c;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        stop_i  = 1'b0;
        clear_i = 1'b0;
    endtask

    task automatic run_until(input logic [7:0] val, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (count_o == val) break;
            step(1'b0, 1'b0, 1'b0);
        end
        chk("run_until", count_o, val);
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 8'h02, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 8'h02, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 8'h02, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 8'h02, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0};
        tbl[14] = '{1'b1, 1'b0, 1'b0, 8'h02, 1'b1, 1'b0};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 8'h02, 1'b1, 1'b0};
        tbl[16] = '{1'b0, 1'b0, 1'b0, 8'h03, 1'b1, 1'b0};
        tbl[17] = '{1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};

        rst = 1'b1; start_i = 1'b0; stop_i = 1'b0; clear_i = 1'b0; lap_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_count", count_o, 8'h00);
        chk("reset_running", {7'd0, running_o}, 8'h00);
        chk("reset_wrap", {7'd0, wrap_o}, 8'h00);
        rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            step(tbl[i].st, tbl[i].sp, tbl[i].cl);
            chk($sformatf("vec%0d_count", i), count_o, tbl[i].cnt);
            chk($sformatf("vec%0d_running", i), {7'd0, running_o}, {7'd0, tbl[i].run});
            chk($sformatf("vec%0d_wrap", i), {7'd0, wrap_o}, {7'd0, tbl[i].wr});
        end

        // Digit-0 to digit-1 carry
        step(1'b1, 1'b0, 1'b0);
        run_until(8'h09, 60);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0);
            chk("hold_09", count_o, 8'h09);
        end
        step(1'b0, 1'b0, 1'b0);
        chk("carry_10", count_o, 8'h10);

        // Full-scale wrap
        run_until(8'h99, 400);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0);
            chk("pre_wrap_flag", {7'd0, wrap_o}, 8'h00);
        end
        step(1'b0, 1'b0, 1'b0);
        chk("wrap_count", count_o, 8'h00);
        chk("wrap_flag", {7'd0, wrap_o}, 8'h01);
        chk("wrap_running", {7'd0, running_o}, 8'h01);
        step(1'b0, 1'b0, 1'b0);
        chk("wrap_pulse_end", {7'd0, wrap_o}, 8'h00);

        // Pause two cycles after an increment; resume keeps the phase
        step(1'b0, 1'b1, 1'b0);
        chk("pause_running", {7'd0, running_o}, 8'h00);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, 1'b0);
            chk("pause_frozen", count_o, 8'h00);
        end
        step(1'b1, 1'b0, 1'b0);
        chk("resume_running", {7'd0, running_o}, 8'h01);
        chk("resume_count", count_o, 8'h00);
        step(1'b0, 1'b0, 1'b0);
        chk("resume_plus1", count_o, 8'h00);
        step(1'b0, 1'b0, 1'b0);
        chk("resume_plus2", count_o, 8'h01);

        // All three commands together: clear wins
        run_until(8'h37, 300);
        step(1'b1, 1'b1, 1'b1);
        chk("triple_count", count_o, 8'h00);
        chk("triple_running", {7'd0, running_o}, 8'h00);
        step(1'b0, 1'b0, 1'b0);
        chk("idle_count", count_o, 8'h00);
        chk("idle_running", {7'd0, running_o}, 8'h00);

        // Asynchronous reset mid-cycle
        step(1'b1, 1'b0, 1'b0);
        run_until(8'h55, 400);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_count", count_o, 8'h00);
        chk("async_rst_running", {7'd0, running_o}, 8'h00);
        #1;
        rst = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        chk("post_rst_idle", {7'd0, running_o}, 8'h00);

`ifdef LAP_STOPWATCH_EN
        step(1'b1, 1'b0, 1'b0);
        run_until(8'h12, 100);
        lap_i = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        chk("lap_enter", count_o, 8'h12);
        for (int i = 0; i < 11; i++) begin
            step(1'b0, 1'b0, 1'b0);
            chk("lap_hold", count_o, 8'h12);
        end
        lap_i = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        chk("lap_release_low", count_o, 8'h12);
        lap_i = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        chk("lap_exit", count_o, 8'h15);
        lap_i = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
